bcd_calc_ctrl: RTL and testbench
================================

Name: bcd_calc_ctrl

Overview:
Sequencing controller for the single-digit BCD add/subtract calculator datapath. It takes raw keypad and operator buttons, debounces them and priority-encodes them. A five-state FSM then produces the operand load strobes, the add/subtract select, the result latch strobe and the datapath clear. It replaces the direct key-driven clocking of the operand and result registers with synchronous, single-cycle enables on one clock.

Parameters:
DB_CYCLES, 4, consecutive stable samples required to accept a press or a release (range 2..65535)
CNT_W, 16, debounce counter width; must satisfy 2**CNT_W > DB_CYCLES

Ports:
CLK  input  1  system clock, rising edge
CLRb  input  1  asynchronous active-low reset
KEY_n  input  10  digit keys 0..9, active-low, bit i = digit i
ADD  input  1  add key, active-high
SUB  input  1  subtract key, active-high
EQUAL  input  1  equal key, active-high
CLR  input  1  clear key, active-high
DIGIT  output  4  BCD code of the last accepted digit
LD_A  output  1  one-cycle strobe: load DIGIT into operand A register
LD_B  output  1  one-cycle strobe: load DIGIT into operand B register
Addn_Sub  output  1  0 = add, 1 = subtract; level
LD_RES  output  1  one-cycle strobe: latch adder result
DP_CLRb  output  1  active-low synchronous clear to datapath registers
STATE  output  3  current FSM state code
ERR  output  1  sticky: an event was ignored in the current state

Behaviour:
- Reset (CLRb=0, async) sets these values:
  - STATE=IDLE(0), DIGIT=0, Addn_Sub=0, ERR=0.
  - LD_A, LD_B and LD_RES = 0.
  - DP_CLRb=0. It goes to 1 on the first CLK edge after CLRb rises.
- Input conditioning:
  - Raw vector V = {CLR, EQUAL, SUB, ADD, ~KEY_n[9:0]} passes through a 2-flop synchronizer.
  - The counter clears whenever the synchronized V differs from its previous sample and increments otherwise, saturating.
- Press event:
  - Fires when a nonzero V has been stable for DB_CYCLES samples while the block is armed. Firing disarms the block.
  - Strobe outputs rise exactly DB_CYCLES+2 rising edges after the input settles.
- Rearm: V=0 stable for DB_CYCLES samples.
  - Changing from one nonzero V to another without a release generates no event.
  - Pulses shorter than DB_CYCLES generate nothing.
- Priority encoding, for simultaneous bits in the accepted V: CLR > EQUAL > SUB > ADD > digit 9 > ... > digit 0.
- FSM (state codes 0..4). Every event is decoded in the cycle it fires, and all strobes are one cycle wide.
  - IDLE(0): digit d -> DIGIT=d, LD_A, go to GOT_A. ADD/SUB/EQUAL are ignored and set ERR.
  - GOT_A(1): digit -> DIGIT=d, LD_A (replace A), stay. ADD -> Addn_Sub=0, go to OP. SUB -> Addn_Sub=1, go to OP. EQUAL is ignored and sets ERR.
  - OP(2): digit -> DIGIT=d, LD_B, go to GOT_B. ADD/SUB -> update Addn_Sub, stay. EQUAL is ignored and sets ERR.
  - GOT_B(3): digit -> DIGIT=d, LD_B (replace B), stay. ADD/SUB -> update Addn_Sub, stay. EQUAL -> LD_RES, go to RESULT.
  - RESULT(4): digit -> DIGIT=d, LD_A, go to GOT_A; Addn_Sub is held. ADD/SUB/EQUAL are ignored and set ERR.
  - CLR in any state -> DP_CLRb=0 for one cycle, STATE=IDLE, Addn_Sub=0, DIGIT=0, ERR=0.
- Addn_Sub is stable from the operator event through the LD_RES cycle; the datapath is combinational within one cycle.
- DIGIT changes in the same cycle as LD_A/LD_B and holds until the next digit event.
- Unused state codes 5..7 return to IDLE on the next edge with DP_CLRb=0 for one cycle.
- Reset mid-debounce or mid-strobe aborts immediately. No event is emitted after release of CLRb until V=0 has been seen for DB_CYCLES samples.

Test Plan (DB_CYCLES=4):
- Reset, then KEY_n[3]=0 held for 10 cycles -> exactly one LD_A, with DIGIT=3 and STATE=1, on the 6th edge after the change.
- Sequence 7, SUB, 2, EQUAL (each pressed, then released for 8 cycles):
  - LD_A with DIGIT=7, then Addn_Sub=1, then LD_B with DIGIT=2.
  - Then one LD_RES with Addn_Sub=1, and STATE=4.
- Glitch: KEY_n[5] low for 3 cycles -> no strobe. Holding KEY_n[5] and KEY_n[8] low together -> DIGIT=8.
- Press EQUAL in IDLE -> no strobe, ERR=1. A following CLR press -> DP_CLRb low for one cycle, ERR=0, STATE=0.
- Hold ADD, then add KEY_n[4] without releasing -> no second event. Release, then press 4 -> LD_B with DIGIT=4.
- Assert CLRb=0 asynchronously during an LD_B cycle -> all outputs go to reset values immediately, with no glitch strobe after release.

Source files
------------

// File: rtl/bcd_calc_ctrl.sv
// bcd_calc_ctrl
// Sequencing controller for a single-digit BCD add/subtract calculator.
// Raw keys are synchronized, debounced and priority-encoded into single
// press events. A five-state FSM turns those events into one-cycle load
// strobes and level controls for the operand/result datapath, all on CLK.
//
// Ports:
//   CLK      in   system clock, rising edge
//   CLRb     in   asynchronous active-low reset
//   KEY_n    in   [9:0] digit keys, active-low, bit i = digit i
//   ADD      in   add key, active-high
//   SUB      in   subtract key, active-high
//   EQUAL    in   equal key, active-high
//   CLR      in   clear key, active-high
//   DIGIT    out  [3:0] BCD code of the last accepted digit
//   LD_A     out  one-cycle load strobe for operand A
//   LD_B     out  one-cycle load strobe for operand B
//   Addn_Sub out  0 = add, 1 = subtract (level)
//   LD_RES   out  one-cycle result latch strobe
//   DP_CLRb  out  active-low synchronous datapath clear
//   STATE    out  [2:0] current FSM state code
//   ERR      out  sticky flag: an event was ignored in the current state
//
// State   | meaning
// --------+---------------------------------------------
// IDLE    | cleared, waiting for first operand digit
// GOT_A   | operand A loaded, digit replaces A
// OP      | operator selected, waiting for operand B
// GOT_B   | operand B loaded, EQUAL latches the result
// RESULT  | result latched, next digit starts a new A

module bcd_calc_ctrl #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 16
) (
    input  logic       CLK,
    input  logic       CLRb,
    input  logic [9:0] KEY_n,
    input  logic       ADD,
    input  logic       SUB,
    input  logic       EQUAL,
    input  logic       CLR,
    output logic [3:0] DIGIT,
    output logic       LD_A,
    output logic       LD_B,
    output logic       Addn_Sub,
    output logic       LD_RES,
    output logic       DP_CLRb,
    output logic [2:0] STATE,
    output logic       ERR
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GOT_A  = 3'd1,
        S_OP     = 3'd2,
        S_GOT_B  = 3'd3,
        S_RESULT = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(DB_CYCLES - 1);
    localparam logic [3:0] EV_ADD   = 4'd10;
    localparam logic [3:0] EV_SUB   = 4'd11;
    localparam logic [3:0] EV_EQUAL = 4'd12;
    localparam logic [3:0] EV_CLR   = 4'd13;

    // ---------------- input conditioning ----------------
    logic [13:0]      v_raw;
    logic [13:0]      v_meta;
    logic [13:0]      v_sync;
    logic [CNT_W-1:0] cnt;
    logic             armed;
    logic             stable;
    logic             fire;
    logic [3:0]       ev_code;

    assign v_raw = {CLR, EQUAL, SUB, ADD, ~KEY_n};

    // v_meta is the sample v_sync takes next, so comparing the two tells
    // whether the synchronized vector is about to change. cnt then holds
    // (number of consecutive identical v_sync samples - 1).
    always_ff @(posedge CLK or negedge CLRb) begin
        if (!CLRb) begin
            v_meta <= '0;
            v_sync <= '0;
            cnt    <= '0;
            armed  <= 1'b0;
        end else begin
            v_meta <= v_raw;
            v_sync <= v_meta;
            if (v_meta != v_sync) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
            // Starts disarmed so a key held through reset never fires.
            if (fire) begin
                armed <= 1'b0;
            end else if (stable && (v_sync == '0)) begin
                armed <= 1'b1;
            end
        end
    end

    assign stable = (cnt >= STABLE_CNT);
    assign fire   = armed && stable && (v_sync != '0);

    // Highest set bit wins: CLR > EQUAL > SUB > ADD > digit 9 > ... > 0.
    always_comb begin
        ev_code = '0;
        for (int i = 0; i < 14; i++) begin
            if (v_sync[i]) begin
                ev_code = 4'(i);
            end
        end
    end

    // ---------------- sequencing FSM ----------------
    state_t     state_q, state_d;
    logic [3:0] digit_q, digit_d;
    logic       as_q, as_d;
    logic       err_q, err_d;
    logic       ld_a_q, ld_a_d;
    logic       ld_b_q, ld_b_d;
    logic       ld_res_q, ld_res_d;
    logic       dp_clr_b_q, dp_clr_b_d;
    logic       ev_digit;

    assign ev_digit = (ev_code <= 4'd9);

    always_ff @(posedge CLK or negedge CLRb) begin
        if (!CLRb) begin
            state_q    <= S_IDLE;
            digit_q    <= '0;
            as_q       <= 1'b0;
            err_q      <= 1'b0;
            ld_a_q     <= 1'b0;
            ld_b_q     <= 1'b0;
            ld_res_q   <= 1'b0;
            dp_clr_b_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            digit_q    <= digit_d;
            as_q       <= as_d;
            err_q      <= err_d;
            ld_a_q     <= ld_a_d;
            ld_b_q     <= ld_b_d;
            ld_res_q   <= ld_res_d;
            dp_clr_b_q <= dp_clr_b_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        digit_d    = digit_q;
        as_d       = as_q;
        err_d      = err_q;
        ld_a_d     = 1'b0;
        ld_b_d     = 1'b0;
        ld_res_d   = 1'b0;
        dp_clr_b_d = 1'b1;

        case (state_q)
            S_IDLE, S_GOT_A, S_OP, S_GOT_B, S_RESULT: begin
                if (fire && (ev_code == EV_CLR)) begin
                    state_d    = S_IDLE;
                    digit_d    = '0;
                    as_d       = 1'b0;
                    err_d      = 1'b0;
                    dp_clr_b_d = 1'b0;
                end else if (fire) begin
                    case (state_q)
                        S_GOT_A: begin
                            if (ev_digit) begin
                                digit_d = ev_code;
                                ld_a_d  = 1'b1;
                            end else if (ev_code == EV_ADD || ev_code == EV_SUB) begin
                                as_d    = (ev_code == EV_SUB);
                                state_d = S_OP;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        S_OP: begin
                            if (ev_digit) begin
                                digit_d = ev_code;
                                ld_b_d  = 1'b1;
                                state_d = S_GOT_B;
                            end else if (ev_code == EV_ADD || ev_code == EV_SUB) begin
                                as_d = (ev_code == EV_SUB);
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        S_GOT_B: begin
                            if (ev_digit) begin
                                digit_d = ev_code;
                                ld_b_d  = 1'b1;
                            end else if (ev_code == EV_ADD || ev_code == EV_SUB) begin
                                as_d = (ev_code == EV_SUB);
                            end else if (ev_code == EV_EQUAL) begin
                                ld_res_d = 1'b1;
                                state_d  = S_RESULT;
                            end
                        end
                        default: begin
                            // IDLE and RESULT: only a digit is meaningful,
                            // and it starts a fresh operand A. Addn_Sub holds.
                            if (ev_digit) begin
                                digit_d = ev_code;
                                ld_a_d  = 1'b1;
                                state_d = S_GOT_A;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                    endcase
                end
            end
            default: begin
                // Illegal code: recover to IDLE and clear the datapath.
                state_d    = S_IDLE;
                digit_d    = '0;
                as_d       = 1'b0;
                err_d      = 1'b0;
                dp_clr_b_d = 1'b0;
            end
        endcase
    end

    assign DIGIT    = digit_q;
    assign LD_A     = ld_a_q;
    assign LD_B     = ld_b_q;
    assign Addn_Sub = as_q;
    assign LD_RES   = ld_res_q;
    assign DP_CLRb  = dp_clr_b_q;
    assign STATE    = state_q;
    assign ERR      = err_q;

endmodule

// File: tb/tb_bcd_calc_ctrl.sv
// Testbench for bcd_calc_ctrl: directed steps from the test plan followed by
// random key presses, compared against a calculator-level reference model.

module tb_bcd_calc_ctrl;

    localparam int DB = 4;
    localparam int M_IDLE = 0, M_GOTA = 1, M_OP = 2, M_GOTB = 3, M_RES = 4;
    localparam logic [13:0] K_ADD = 14'h0400;
    localparam logic [13:0] K_SUB = 14'h0800;
    localparam logic [13:0] K_EQ  = 14'h1000;
    localparam logic [13:0] K_CLR = 14'h2000;

    logic       CLK = 1'b0;
    logic       CLRb;
    logic [9:0] KEY_n;
    logic       ADD, SUB, EQUAL, CLR;
    logic [3:0] DIGIT;
    logic       LD_A, LD_B, Addn_Sub, LD_RES, DP_CLRb, ERR;
    logic [2:0] STATE;

    bcd_calc_ctrl #(.DB_CYCLES(DB), .CNT_W(16)) dut (
        .CLK(CLK), .CLRb(CLRb), .KEY_n(KEY_n), .ADD(ADD), .SUB(SUB),
        .EQUAL(EQUAL), .CLR(CLR), .DIGIT(DIGIT), .LD_A(LD_A), .LD_B(LD_B),
        .Addn_Sub(Addn_Sub), .LD_RES(LD_RES), .DP_CLRb(DP_CLRb),
        .STATE(STATE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // reference calculator model
    int m_state = M_IDLE;
    int m_digit = 0;
    int m_as    = 0;
    int m_err   = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] dkey(input int d);
        logic [13:0] one = 14'd1;
        return one << d;
    endfunction

    function automatic int prio(input logic [13:0] v);
        int p = -1;
        for (int i = 0; i < 14; i++) if (v[i]) p = i;
        return p;
    endfunction

    task automatic drive(input logic [13:0] v);
        KEY_n = ~v[9:0];
        ADD   = v[10];
        SUB   = v[11];
        EQUAL = v[12];
        CLR   = v[13];
    endtask

    // ev: 0..9 digit, 10 ADD, 11 SUB, 12 EQUAL, 13 CLR, -1 none
    task automatic model_event(input int ev, output int ea, output int eb,
                               output int er, output int ec);
        ea = 0; eb = 0; er = 0; ec = 0;
        if (ev == 13) begin
            ec = 1; m_state = M_IDLE; m_digit = 0; m_as = 0; m_err = 0;
        end else if (ev >= 0 && ev <= 9) begin
            m_digit = ev;
            if (m_state == M_OP || m_state == M_GOTB) begin
                eb = 1; m_state = M_GOTB;
            end else begin
                ea = 1; m_state = M_GOTA;
            end
        end else if (ev == 10 || ev == 11) begin
            if (m_state == M_IDLE || m_state == M_RES) m_err = 1;
            else begin
                m_as = (ev == 11) ? 1 : 0;
                if (m_state == M_GOTA) m_state = M_OP;
            end
        end else if (ev == 12) begin
            if (m_state == M_GOTB) begin
                er = 1; m_state = M_RES;
            end else m_err = 1;
        end
    endtask

    // Drive v1 for h1 cycles, then v2 for h2 cycles, then release and watch
    // ten more cycles. Edge numbers count rising edges after v1 is applied.
    task automatic press(input string tag, input logic [13:0] v1, input int h1,
                         input logic [13:0] v2, input int h2);
        int ev = -1;
        int edge_exp = 0;
        int ea, eb, er, ec;
        int ca = 0, cb = 0, cr = 0, cc = 0, first = 0, as_at_res = 0;
        int n;
        if (v1 != 0 && h1 >= DB) begin
            ev = prio(v1); edge_exp = DB + 2;
        end else if (v2 != 0 && h2 >= DB) begin
            ev = prio(v2); edge_exp = h1 + DB + 2;
        end
        model_event(ev, ea, eb, er, ec);
        if (ea + eb + er + ec == 0) edge_exp = 0;
        drive(v1);
        n = h1 + h2 + 10;
        for (int e = 1; e <= n; e++) begin
            @(posedge CLK); #1;
            if (LD_A) ca++;
            if (LD_B) cb++;
            if (LD_RES) begin cr++; as_at_res = int'(Addn_Sub); end
            if (!DP_CLRb) cc++;
            if ((LD_A || LD_B || LD_RES || !DP_CLRb) && first == 0) first = e;
            if (e == h1) drive(v2);
            if (e == h1 + h2) drive('0);
        end
        check({tag, "/ld_a_cnt"}, 16'(ca), 16'(ea));
        check({tag, "/ld_b_cnt"}, 16'(cb), 16'(eb));
        check({tag, "/ld_res_cnt"}, 16'(cr), 16'(er));
        check({tag, "/dp_clr_cnt"}, 16'(cc), 16'(ec));
        check({tag, "/strobe_edge"}, 16'(first), 16'(edge_exp));
        if (er != 0) check({tag, "/as_at_res"}, 16'(as_at_res), 16'(m_as));
        check({tag, "/digit"}, 16'(DIGIT), 16'(m_digit));
        check({tag, "/state"}, 16'(STATE), 16'(m_state));
        check({tag, "/addn_sub"}, 16'(Addn_Sub), 16'(m_as));
        check({tag, "/err"}, 16'(ERR), 16'(m_err));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "/state"}, 16'(STATE), 16'd0);
        check({tag, "/digit"}, 16'(DIGIT), 16'd0);
        check({tag, "/addn_sub"}, 16'(Addn_Sub), 16'd0);
        check({tag, "/err"}, 16'(ERR), 16'd0);
        check({tag, "/strobes"}, 16'({LD_A, LD_B, LD_RES}), 16'd0);
        check({tag, "/dp_clrb"}, 16'(DP_CLRb), 16'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int cnt_bad;
        logic [13:0] rv;
        int kind;

        // --- reset ---
        CLRb = 1'b0;
        drive('0);
        #3;
        check_reset_outputs("reset");
        #9;
        CLRb = 1'b1;
        @(posedge CLK); #1;
        check("reset_release/dp_clrb", 16'(DP_CLRb), 16'd1);
        repeat (10) begin @(posedge CLK); #1; end

        // --- first digit, latency DB+2 ---
        press("key3", dkey(3), 10, '0, 0);

        // --- 7, SUB, 2, EQUAL ---
        press("key7", dkey(7), 6, '0, 0);
        press("sub", K_SUB, 6, '0, 0);
        press("key2", dkey(2), 6, '0, 0);
        press("equal", K_EQ, 6, '0, 0);

        // --- glitch and multi-key priority ---
        press("glitch5", dkey(5), DB - 1, '0, 0);
        press("key5_8", dkey(5) | dkey(8), 6, '0, 0);

        // --- ignored EQUAL, then clear ---
        press("clr_a", K_CLR, 6, '0, 0);
        press("eq_idle", K_EQ, 6, '0, 0);
        press("clr_b", K_CLR, 6, '0, 0);

        // --- held operator with an added key gives no second event ---
        press("key1", dkey(1), 6, '0, 0);
        press("add_hold", K_ADD, 10, K_ADD | dkey(4), 10);
        press("key4", dkey(4), 6, '0, 0);

        // --- async reset during an LD_B strobe ---
        drive(dkey(5));
        seen = 0;
        for (int e = 1; e <= 20 && seen == 0; e++) begin
            @(posedge CLK); #1;
            if (LD_B) seen = 1;
        end
        check("midrst/ld_b_seen", 16'(seen), 16'd1);
        CLRb = 1'b0;
        #1;
        check_reset_outputs("midrst");
        m_state = M_IDLE; m_digit = 0; m_as = 0; m_err = 0;
        #2;
        CLRb = 1'b1;
        cnt_bad = 0;
        for (int e = 1; e <= 15; e++) begin
            @(posedge CLK); #1;
            if (LD_A || LD_B || LD_RES || !DP_CLRb) cnt_bad++;
        end
        check("midrst/held_no_strobe", 16'(cnt_bad), 16'd0);
        drive('0);
        cnt_bad = 0;
        for (int e = 1; e <= 10; e++) begin
            @(posedge CLK); #1;
            if (LD_A || LD_B || LD_RES || !DP_CLRb) cnt_bad++;
        end
        check("midrst/release_no_strobe", 16'(cnt_bad), 16'd0);
        check("midrst/state", 16'(STATE), 16'd0);
        press("post_rst6", dkey(6), 6, '0, 0);

        // --- random presses ---
        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 9));
            if (kind <= 4) rv = dkey(int'($urandom_range(0, 9)));
            else if (kind == 5) rv = K_ADD;
            else if (kind == 6) rv = K_SUB;
            else if (kind == 7) rv = K_EQ;
            else if (kind == 8) rv = ($urandom_range(0, 3) == 0) ? K_CLR : dkey(int'($urandom_range(0, 9)));
            else rv = 14'($urandom_range(1, 14'h1FFF));
            press($sformatf("rand%0d", i), rv, int'($urandom_range(DB - 2, DB + 5)), '0, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
